keypad_decoder: RTL and testbench
=================================

# keypad_decoder

Column-side companion to the keypad row scanner. It samples the active-low keypad columns against the active-low row the scanner is driving and debounces presses over several scan rounds. It rejects multi-key ghosting and presents one 4-bit key code per physical press through a valid/ready handshake. While a decoded key waits for the consumer, it asserts `freeze` back to the scanner to park the scan.

## Interface
Parameters:
- `DEBOUNCE`, default 3: consecutive scan-round visits needed to accept a press or a release (range 1..15).
- `SETTLE`, default 3: cycles of samples ignored after `freeze` drops, so the row/column pipelines realign.

Ports:
- `clk` in 1: single clock, shared with the row scanner.
- `reset` in 1: asynchronous, active-low. The block is held in reset while `reset` = 0.
- `row` in 4: scanner row drive, one-hot-low (1110 = row 0 … 0111 = row 3).
- `col` in 4: raw keypad columns, active-low, pulled up, asynchronous (bit i = column i).
- `key_ready` in 1: consumer accepts the key on a clock edge where `key_valid` and `key_ready` are both 1.
- `key_valid` out 1: a decoded key is pending.
- `key_code` out 4: `row_index*4 + col_index`. Stable while `key_valid` = 1.
- `freeze` out 1: to the scanner. 1 = hold the current row.

## Operation
Sampling pipeline:
- `col` passes through a 2-FF synchronizer to produce `col_s`.
- `row` passes through a matching 2-stage delay to produce `row_d`, so `col_s` and `row_d` refer to the same scan cycle.
- A sample is valid only if all of the following hold:
  - `row_d` is one of the four one-hot-low codes;
  - the FSM is not in PENDING;
  - the settle counter is 0.
- Any other `row_d` value (0000, 1111, X after power-up) makes the sample invalid and it is ignored.

FSM states are IDLE, CONFIRM, PENDING and RELEASE. All outputs are registered.
- IDLE:
  - On a valid sample with exactly one `col_s` bit = 0, latch cand_row/cand_col, set hit = 1 and go to CONFIRM. If `DEBOUNCE` = 1, go straight to PENDING.
  - Samples with zero low columns or with two or more low columns are ignored (ghost rejection).
- CONFIRM: only valid samples where `row_d` = cand_row are evaluated. Samples for other rows are ignored.
  - `col_s` equals the latched single-low pattern: hit++. When hit reaches `DEBOUNCE`, load `key_code`, set `key_valid` = 1 and `freeze` = 1, then go to PENDING.
  - Any other `col_s`: return to IDLE, with no output.
- PENDING:
  - Hold `key_valid`, `key_code` and `freeze`.
  - On the handshake edge, clear `key_valid` and `freeze`, load settle = `SETTLE`, clear the release count and go to RELEASE.
- RELEASE: only valid samples with `row_d` = cand_row are evaluated.
  - cand_col bit = 1: rel++.
  - cand_col bit = 0: rel = 0.
  - When rel reaches `DEBOUNCE`, go to IDLE. A held key therefore never produces a second code (no auto-repeat).
- Settle counter: decrements every cycle while nonzero, in any state.
- Counters saturate at `DEBOUNCE` and are 4 bits wide.

## Timing
- Reset values: `key_valid` = 0, `key_code` = 0000, `freeze` = 0, state = IDLE, synchronizer and delay stages = 1111, all counters 0. The clear is immediate on `reset` = 0, including mid-press and while PENDING.
- Latency from `col` to `col_s` is 2 cycles. Row alignment has the same 2 cycles.
- `key_valid` and `freeze` rise on the edge after the `DEBOUNCE`-th matching sample. The scanner parks on the following edge, and `row` is constant afterwards.
- `key_ready` = 1 while `key_valid` = 0 has no effect.
- If `key_ready` is already 1 when `key_valid` rises, the handshake completes on the next edge, so `key_valid` is high for exactly 1 cycle.
- `freeze` falls on the same edge as `key_valid`. The scan resumes. No decision is made for `SETTLE` cycles.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state encoding (2 bits);
  - the row codes ROW0..ROW3 = 1110/1101/1011/0111;
  - the all-released column constant 1111.
- Sub-module `keypad_sync2` (parameterised width, 2-FF, reset to 1) for `col`. The row delay is inline.
- Row and column index encoders are inline combinational functions.

## Test plan
All scenarios use a scanner model, `DEBOUNCE` = 3 and `SETTLE` = 3.
- Reset: drive `reset` = 0 mid-scan → `key_valid` = 0, `key_code` = 0000 and `freeze` = 0 within the same cycle. After release, the first decision comes no earlier than 3 cycles later.
- Clean press: hold row 1 / col 2 (`col` = 1011 when `row` = 1101), `key_ready` = 0 → after the 3rd row-1 visit, `key_valid` = 1, `key_code` = 0110 (6), `freeze` = 1. These hold until `key_ready` = 1, then all drop on that edge.
- Bounce: col 2 low for only 2 row-1 visits, then high → `key_valid` stays 0 and the FSM returns to IDLE.
- Ghosting: `col` = 1001 on row 2 for 10 rounds → no `key_valid`. Code 15 (row 3, col 3) pressed alone → `key_code` = 1111.
- No repeat: keep key 6 held after the handshake → no second `key_valid`. Release for 3 row-1 visits, then press again → `key_valid` with `key_code` = 6.
- Reset while PENDING: `key_valid` = 1, then `reset` = 0 for 1 cycle → outputs are cleared and `freeze` = 0. With the key still held, a fresh debounce is required before `key_valid` rises again.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared FSM encoding and row/column codes for keypad_decoder
// Revision   : 1.0  initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_PENDING = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] c_ROW0         = 4'b1110;
  localparam logic [3:0] c_ROW1         = 4'b1101;
  localparam logic [3:0] c_ROW2         = 4'b1011;
  localparam logic [3:0] c_ROW3         = 4'b0111;
  localparam logic [3:0] c_COL_RELEASED = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/keypad_sync2.sv
`default_nettype none
// ============================================================================
// keypad_sync2 : 2-FF synchronizer, resets to all-ones (released / idle level)
// Revision     : 1.0  initial release
// ============================================================================
module keypad_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_decoder.sv
`default_nettype none
// ============================================================================
// keypad_decoder : debounced, ghost-rejecting column decoder with valid/ready
// Revision       : 1.0  initial release
// ============================================================================
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int SETTLE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       freeze
);

  localparam logic [3:0] c_DEB = 4'(DEBOUNCE);
  localparam logic [3:0] c_SET = 4'(SETTLE);

  function automatic logic [1:0] row_index(input logic [3:0] r);
    case (r)
      c_ROW1:  return 2'd1;
      c_ROW2:  return 2'd2;
      c_ROW3:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic single_low(input logic [3:0] c);
    return ($countones(~c) == 1);
  endfunction

  logic [3:0] w_col_s;
  logic [3:0] r_row_q1, r_row_d;
  state_t     r_state, w_state_n;
  logic [3:0] r_cand_row, w_cand_row_n;
  logic [3:0] r_cand_col, w_cand_col_n;
  logic [3:0] r_hit, w_hit_n;
  logic [3:0] r_rel, w_rel_n;
  logic [3:0] r_settle, w_settle_n;
  logic       r_valid, w_valid_n;
  logic [3:0] r_code, w_code_n;
  logic       r_freeze, w_freeze_n;

  keypad_sync2 #(.WIDTH(4)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (col),
    .o_q   (w_col_s)
  );

  // Row delay matches the synchronizer so row_d and col_s describe the same scan cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_q1 <= 4'b1111;
      r_row_d  <= 4'b1111;
    end else begin
      r_row_q1 <= row;
      r_row_d  <= r_row_q1;
    end
  end

  logic w_row_ok, w_sample, w_on_cand;
  logic [3:0] w_hit_inc, w_rel_inc;

  assign w_row_ok  = (r_row_d == c_ROW0) || (r_row_d == c_ROW1) ||
                     (r_row_d == c_ROW2) || (r_row_d == c_ROW3);
  assign w_sample  = w_row_ok && (r_state != S_PENDING) && (r_settle == 4'd0);
  assign w_on_cand = w_sample && (r_row_d == r_cand_row);
  assign w_hit_inc = (r_hit >= c_DEB) ? r_hit : r_hit + 4'd1;
  assign w_rel_inc = (r_rel >= c_DEB) ? r_rel : r_rel + 4'd1;

  always_comb begin
    w_state_n    = r_state;
    w_cand_row_n = r_cand_row;
    w_cand_col_n = r_cand_col;
    w_hit_n      = r_hit;
    w_rel_n      = r_rel;
    w_settle_n   = (r_settle != 4'd0) ? r_settle - 4'd1 : 4'd0;
    w_valid_n    = r_valid;
    w_code_n     = r_code;
    w_freeze_n   = r_freeze;

    case (r_state)
      S_IDLE: begin
        // Zero or multiple low columns are ghosting/idle and never start a press
        if (w_sample && single_low(w_col_s)) begin
          w_cand_row_n = r_row_d;
          w_cand_col_n = w_col_s;
          w_hit_n      = 4'd1;
          if (c_DEB <= 4'd1) begin
            w_valid_n  = 1'b1;
            w_freeze_n = 1'b1;
            w_code_n   = {row_index(r_row_d), col_index(w_col_s)};
            w_state_n  = S_PENDING;
          end else begin
            w_state_n  = S_CONFIRM;
          end
        end
      end
      S_CONFIRM: begin
        if (w_on_cand) begin
          if (w_col_s == r_cand_col) begin
            w_hit_n = w_hit_inc;
            if (w_hit_inc >= c_DEB) begin
              w_valid_n  = 1'b1;
              w_freeze_n = 1'b1;
              w_code_n   = {row_index(r_cand_row), col_index(r_cand_col)};
              w_state_n  = S_PENDING;
            end
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      S_PENDING: begin
        if (key_ready && r_valid) begin
          w_valid_n  = 1'b0;
          w_freeze_n = 1'b0;
          w_settle_n = c_SET;
          w_rel_n    = 4'd0;
          w_state_n  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (w_on_cand) begin
          if ((w_col_s | r_cand_col) == c_COL_RELEASED) begin
            w_rel_n = w_rel_inc;
            if (w_rel_inc >= c_DEB) w_state_n = S_IDLE;
          end else begin
            w_rel_n = 4'd0;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cand_row <= 4'b1111;
      r_cand_col <= 4'b1111;
      r_hit      <= 4'd0;
      r_rel      <= 4'd0;
      r_settle   <= 4'd0;
      r_valid    <= 1'b0;
      r_code     <= 4'd0;
      r_freeze   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cand_row <= w_cand_row_n;
      r_cand_col <= w_cand_col_n;
      r_hit      <= w_hit_n;
      r_rel      <= w_rel_n;
      r_settle   <= w_settle_n;
      r_valid    <= w_valid_n;
      r_code     <= w_code_n;
      r_freeze   <= w_freeze_n;
    end
  end

  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign freeze    = r_freeze;

endmodule
`default_nettype wire

// File: tb/tb_keypad_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_keypad_decoder : scanner + keypad model, vector table, directed and random
// Revision          : 1.0  initial release
// ============================================================================
module tb_keypad_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_ready;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        freeze;

  logic [15:0] pressed;
  bit          mon_on;
  int          n_tests;
  int          n_fail;
  int          exp_q[$];

  typedef struct {
    logic [15:0] mask;
    logic        exp_valid;
    logic [3:0]  exp_code;
  } vec_t;

  keypad_decoder #(.DEBOUNCE(3), .SETTLE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .key_code  (key_code),
    .freeze    (freeze)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pressed key k sits at row k/4, column k%4 and pulls its column low while its row is driven
  function automatic logic [3:0] keypad_cols(input logic [3:0] r, input logic [15:0] p);
    logic [3:0] c;
    c = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      if (!r[ri])
        for (int ci = 0; ci < 4; ci++)
          if (p[ri*4+ci]) c[ci] = 1'b0;
    return c;
  endfunction

  // Scanner: one row per cycle, parks one edge after freeze is seen
  initial begin
    row = 4'b1110;
    col = 4'b1111;
    forever begin
      @(negedge clk);
      if (!freeze) row = {row[2:0], row[3]};
      col = keypad_cols(row, pressed);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Handshake monitor for the random phase
  initial begin : mon
    int e;
    forever begin
      @(negedge clk);
      if (mon_on && key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rand_spurious: actual code=%0d required=no key", key_code);
        end else begin
          e = exp_q.pop_front();
          chk("rand_code", key_code, e);
          chk("rand_freeze", freeze, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (key_valid) seen = 1'b1;
    end
  endtask

  task automatic visits(input int n);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < n && guard < 200) begin
      tick();
      guard++;
      if (row == 4'b1101) k++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[8];
    bit   seen;
    bit   any;
    int   k, r, c1, c2, hold;
    logic [15:0] m;

    n_tests   = 0;
    n_fail    = 0;
    mon_on    = 1'b0;
    pressed   = '0;
    key_ready = 1'b0;
    reset     = 1'b0;

    vecs[0] = '{16'h0040, 1'b1, 4'd6};
    vecs[1] = '{16'h0001, 1'b1, 4'd0};
    vecs[2] = '{16'h8000, 1'b1, 4'd15};
    vecs[3] = '{16'h0600, 1'b0, 4'd0};
    vecs[4] = '{16'h000F, 1'b0, 4'd0};
    vecs[5] = '{16'h0200, 1'b1, 4'd9};
    vecs[6] = '{16'h1000, 1'b1, 4'd12};
    vecs[7] = '{16'h0030, 1'b0, 4'd0};

    idle(3);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_freeze", freeze, 0);
    reset = 1'b1;
    idle(5);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      pressed   = vecs[v].mask;
      key_ready = 1'b0;
      wait_valid(60, seen);
      chk($sformatf("tbl%0d_valid", v), seen, vecs[v].exp_valid);
      if (seen) begin
        chk($sformatf("tbl%0d_code", v), key_code, vecs[v].exp_code);
        chk($sformatf("tbl%0d_freeze", v), freeze, 1);
        idle(3);
        chk($sformatf("tbl%0d_hold", v), {key_valid, freeze, key_code}, {2'b11, vecs[v].exp_code});
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        chk($sformatf("tbl%0d_drop", v), {key_valid, freeze}, 0);
      end
      pressed = '0;
      idle(40);
    end

    // Bounce: only two row-1 visits with key 6 down
    pressed = 16'h0040;
    visits(2);
    pressed = '0;
    any = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (key_valid || freeze) any = 1'b1;
    end
    chk("bounce_no_valid", any, 0);

    // Ready already high: valid lasts exactly one cycle
    key_ready = 1'b1;
    idle(5);
    chk("ready_idle_no_effect", key_valid, 0);
    pressed = 16'h0200;
    wait_valid(60, seen);
    chk("early_ready_valid", seen, 1);
    chk("early_ready_code", key_code, 9);
    tick();
    chk("early_ready_one_cycle", {key_valid, freeze}, 0);
    key_ready = 1'b0;
    pressed = '0;
    idle(40);

    // No auto-repeat, then re-press after exactly three released visits
    pressed = 16'h0040;
    wait_valid(60, seen);
    chk("norep_first", seen, 1);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (key_valid) any = 1'b1;
    end
    chk("norep_held_no_second", any, 0);
    pressed = '0;
    visits(3);
    pressed = 16'h0040;
    wait_valid(60, seen);
    chk("norep_repress_valid", seen, 1);
    chk("norep_repress_code", key_code, 6);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    pressed = '0;
    idle(40);

    // Reset while PENDING, key kept held
    pressed = 16'h0040;
    wait_valid(60, seen);
    chk("rstp_pending", {seen, freeze}, 2'b11);
    reset = 1'b0;
    #1;
    chk("rstp_async_clear", {key_valid, freeze, key_code}, 0);
    tick();
    reset = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (key_valid) any = 1'b1;
    end
    chk("rstp_no_early_valid", any, 0);
    wait_valid(60, seen);
    chk("rstp_fresh_valid", seen, 1);
    chk("rstp_fresh_code", key_code, 6);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    pressed = '0;
    idle(40);

    // Random presses against a press-level model
    mon_on = 1'b1;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        r  = $urandom_range(0, 3);
        c1 = $urandom_range(0, 3);
        c2 = (c1 + 1 + $urandom_range(0, 2)) % 4;
        m  = '0;
        m[r*4+c1] = 1'b1;
        m[r*4+c2] = 1'b1;
      end else begin
        k = $urandom_range(0, 15);
        m = '0;
        m[k] = 1'b1;
        exp_q.push_back(k);
      end
      pressed = m;
      hold = $urandom_range(20, 50);
      for (int i = 0; i < hold; i++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick();
      end
      pressed = '0;
      for (int i = 0; i < 200 && key_valid; i++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("rand_handshake_done", key_valid, 0);
      for (int i = 0; i < 40; i++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("rand_queue_drained", exp_q.size(), 0);
      exp_q.delete();
    end
    mon_on    = 1'b0;
    key_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
